// File: rtl/serial_pkg.sv
// serial_pkg: shared state encodings and counter-width helper for the serial bit feeder
package serial_pkg;
  localparam logic ST_IDLE  = 1'b0;
  localparam logic ST_SHIFT = 1'b1;
  function automatic int clog2_min1(input int v);
    return ($clog2(v) < 1) ? 1 : $clog2(v);
  endfunction
endpackage

// File: rtl/serial_bit_feeder_if.sv
// serial_bit_feeder_if: valid/ready word handshake into the serialiser
interface serial_bit_feeder_if #(parameter int WIDTH = 8);
  logic [WIDTH-1:0] in_data;
  logic             in_valid;
  logic             in_ready;
  modport master (output in_data, output in_valid, input in_ready);
  modport slave  (input in_data, input in_valid, output in_ready);
endinterface

// File: rtl/bit_period_counter.sv
// bit_period_counter: reload/decrement counter timing how long each bit is held
module bit_period_counter
  import serial_pkg::*;
#(
  parameter int DIV = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic zero
);
  localparam int W = clog2_min1(DIV);
  logic [W-1:0] cnt_q, cnt_d;
  assign zero = (cnt_q == '0);
  always_comb cnt_d = load ? W'(DIV - 1) : (!zero ? cnt_q - W'(1) : cnt_q);
  always_ff @(posedge clk or negedge rst)
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
endmodule

// File: rtl/serial_bit_feeder.sv
// serial_bit_feeder: serialises handshaked parallel words onto a single registered bit line
module serial_bit_feeder
  import serial_pkg::*;
#(
  parameter int   WIDTH     = 8,
  parameter int   DIV       = 1,
  parameter bit   MSB_FIRST = 1'b1,
  parameter logic IDLE_BIT  = 1'b0
) (
  input  logic                 clk,
  input  logic                 rst,
  serial_bit_feeder_if.slave   s,
  output logic                 d_out,
  output logic                 bit_valid,
  output logic                 busy,
  output logic                 frame_done
);
  localparam int BW = $clog2(WIDTH);
  logic             state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BW-1:0]    bitcnt_q, bitcnt_d;
  logic             d_out_q, d_out_d;
  logic             bit_valid_q, bit_valid_d;
  logic             frame_done_q, frame_done_d;
  logic             div_zero, last, step, accept;
  bit_period_counter #(.DIV(DIV)) u_div (
    .clk  (clk),
    .rst  (rst),
    .load (accept | step),
    .zero (div_zero)
  );
  assign busy       = (state_q == ST_SHIFT);
  assign last       = busy && div_zero && (bitcnt_q == '0);
  assign step       = busy && div_zero && (bitcnt_q != '0);
  assign s.in_ready = (state_q == ST_IDLE) || last;
  assign accept     = s.in_valid && s.in_ready;
  always_comb begin
    state_d      = accept ? ST_SHIFT : (last ? ST_IDLE : state_q);
    shreg_d      = accept ? s.in_data : (step ? (MSB_FIRST ? shreg_q << 1 : shreg_q >> 1) : shreg_q);
    bitcnt_d     = accept ? BW'(WIDTH - 1) : (step ? bitcnt_q - BW'(1) : bitcnt_q);
    d_out_d      = accept ? (MSB_FIRST ? s.in_data[WIDTH-1] : s.in_data[0])
                 : step   ? (MSB_FIRST ? shreg_q[WIDTH-2] : shreg_q[1])
                 : last   ? IDLE_BIT : d_out_q;
    bit_valid_d  = accept || step;
    frame_done_d = last;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      state_q      <= ST_IDLE;
      shreg_q      <= '0;
      bitcnt_q     <= '0;
      d_out_q      <= IDLE_BIT;
      bit_valid_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      shreg_q      <= shreg_d;
      bitcnt_q     <= bitcnt_d;
      d_out_q      <= d_out_d;
      bit_valid_q  <= bit_valid_d;
      frame_done_q <= frame_done_d;
    end
  assign d_out      = d_out_q;
  assign bit_valid  = bit_valid_q;
  assign frame_done = frame_done_q;
endmodule

// File: tb/tb_serial_bit_feeder.sv
// tb_serial_bit_feeder: directed checks of serialisation, back-to-back, divided rate, stall and reset
module tb_serial_bit_feeder;
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;
  serial_bit_feeder_if #(.WIDTH(8)) a_if ();
  serial_bit_feeder_if #(.WIDTH(8)) b_if ();
  logic a_d, a_bv, a_busy, a_fd, b_d, b_bv, b_busy, b_fd;
  serial_bit_feeder #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1), .IDLE_BIT(1'b0)) u_a (
    .clk(clk), .rst(rst), .s(a_if.slave), .d_out(a_d), .bit_valid(a_bv), .busy(a_busy), .frame_done(a_fd)
  );
  serial_bit_feeder #(.WIDTH(8), .DIV(3), .MSB_FIRST(1'b0), .IDLE_BIT(1'b0)) u_b (
    .clk(clk), .rst(rst), .s(b_if.slave), .d_out(b_d), .bit_valid(b_bv), .busy(b_busy), .frame_done(b_fd)
  );
  // observed vectors: {d_out, bit_valid, frame_done, busy, in_ready}
  logic [4:0] a_obs, b_obs;
  assign a_obs = {a_d, a_bv, a_fd, a_busy, a_if.in_ready};
  assign b_obs = {b_d, b_bv, b_fd, b_busy, b_if.in_ready};
  int n_cmp = 0;
  int n_bad = 0;

  task automatic test_reset;
    a_if.in_valid = 1'b0; a_if.in_data = '0;
    b_if.in_valid = 1'b0; b_if.in_data = '0;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++;
    if (a_obs !== 5'b00001) begin n_bad++; $display("FAIL reset_a obs=%b exp=%b", a_obs, 5'b00001); end
    n_cmp++;
    if (b_obs !== 5'b00001) begin n_bad++; $display("FAIL reset_b obs=%b exp=%b", b_obs, 5'b00001); end
    @(negedge clk) rst = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (a_obs !== 5'b00001) begin n_bad++; $display("FAIL idle_a k=%0d obs=%b exp=%b", k, a_obs, 5'b00001); end
      n_cmp++;
      if (b_obs !== 5'b00001) begin n_bad++; $display("FAIL idle_b k=%0d obs=%b exp=%b", k, b_obs, 5'b00001); end
    end
  endtask

  task automatic test_single(input logic [7:0] w);
    logic [4:0] e;
    @(posedge clk); #1;
    a_if.in_data = w; a_if.in_valid = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_if.in_valid = 1'b0;
      e = (k <= 8) ? {w[8-k], 1'b1, 1'b0, 1'b1, k == 8} : (k == 9) ? 5'b00101 : 5'b00001;
      n_cmp++;
      if (a_obs !== e) begin n_bad++; $display("FAIL single w=%h k=%0d obs=%b exp=%b", w, k, a_obs, e); end
    end
  endtask

  task automatic test_back_to_back;
    logic [15:0] p;
    logic [4:0]  e;
    p = 16'hA53C;
    @(posedge clk); #1;
    a_if.in_data = 8'hA5; a_if.in_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_if.in_data = 8'h3C;
      if (k == 9) a_if.in_valid = 1'b0;
      e = (k <= 16) ? {p[16-k], 1'b1, k == 9, 1'b1, (k == 8) || (k == 16)}
        : (k == 17) ? 5'b00101 : 5'b00001;
      n_cmp++;
      if (a_obs !== e) begin n_bad++; $display("FAIL b2b k=%0d obs=%b exp=%b", k, a_obs, e); end
    end
  endtask

  task automatic test_div3;
    logic [4:0] e;
    @(posedge clk); #1;
    b_if.in_data = 8'h01; b_if.in_valid = 1'b1;
    for (int k = 1; k <= 26; k++) begin
      @(posedge clk); #1;
      if (k == 1) b_if.in_valid = 1'b0;
      e = (k <= 24) ? {k <= 3, (k - 1) % 3 == 0, 1'b0, 1'b1, k == 24}
        : (k == 25) ? 5'b00101 : 5'b00001;
      n_cmp++;
      if (b_obs !== e) begin n_bad++; $display("FAIL div3 k=%0d obs=%b exp=%b", k, b_obs, e); end
    end
  endtask

  task automatic test_stall;
    logic [4:0] e;
    @(posedge clk); #1;
    a_if.in_data = 8'h00; a_if.in_valid = 1'b1;
    for (int k = 1; k <= 18; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_if.in_valid = 1'b0;
      if (k == 2) begin a_if.in_data = 8'hFF; a_if.in_valid = 1'b1; end
      if (k == 9) a_if.in_valid = 1'b0;
      e = (k <= 8)  ? {1'b0, 1'b1, 1'b0, 1'b1, k == 8}
        : (k <= 16) ? {1'b1, 1'b1, k == 9, 1'b1, k == 16}
        : (k == 17) ? 5'b00101 : 5'b00001;
      n_cmp++;
      if (a_obs !== e) begin n_bad++; $display("FAIL stall k=%0d obs=%b exp=%b", k, a_obs, e); end
    end
  endtask

  task automatic test_reset_mid;
    logic [7:0] w;
    logic [4:0] e;
    w = 8'hA5;
    @(posedge clk); #1;
    a_if.in_data = w; a_if.in_valid = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      @(posedge clk); #1;
      if (k == 1) a_if.in_valid = 1'b0;
      e = {w[8-k], 1'b1, 1'b0, 1'b1, 1'b0};
      n_cmp++;
      if (a_obs !== e) begin n_bad++; $display("FAIL mid_pre k=%0d obs=%b exp=%b", k, a_obs, e); end
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if (a_obs !== 5'b00001) begin n_bad++; $display("FAIL mid_async obs=%b exp=%b", a_obs, 5'b00001); end
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (a_obs !== 5'b00001) begin n_bad++; $display("FAIL mid_hold k=%0d obs=%b exp=%b", k, a_obs, 5'b00001); end
    end
    @(negedge clk) rst = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if (a_obs !== 5'b00001) begin n_bad++; $display("FAIL mid_release obs=%b exp=%b", a_obs, 5'b00001); end
    test_single(8'h0F);
  endtask

  initial begin
    test_reset;
    test_single(8'hA5);
    test_back_to_back;
    test_div3;
    test_stall;
    test_reset_mid;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
